// File: rtl/iot_pkg.sv
// iot_pkg: shared defaults and types for the IoT event scheduler
package iot_pkg;
  localparam int N_DEV_DEFAULT = 4;
  typedef enum logic {IDLE, ISSUE} state_t;
  typedef struct packed {
    logic pend;
    logic dir;
  } ev_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module rr_arbiter #(
  parameter int N_DEV = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_DEV-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_DEV-1:0] gnt,
  output logic [PTR_W-1:0] gnt_id,
  output logic             valid
);
  logic [PTR_W-1:0] idx;
  // scan from the farthest offset down so the nearest requester to ptr wins last
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = N_DEV - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr) + k) % N_DEV);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        valid    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/iot_event_sched.sv
// iot_event_sched: serialises per-device on/off events onto the monitor change/on_off pair; optional STATE_FILTER_EN
module iot_event_sched
  import iot_pkg::*;
#(
  parameter int N_DEV = N_DEV_DEFAULT,
  parameter int PTR_W = $clog2(N_DEV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_req,
  input  logic [N_DEV-1:0] dev_on,
  output logic [N_DEV-1:0] dev_pend,
  output logic             dropped,
  output logic             change,
  output logic             on_off,
  output logic [PTR_W-1:0] grant_id
);
  ev_t              slot_q [N_DEV];
  ev_t              slot_d [N_DEV];
  logic [N_DEV-1:0] gnt;
  logic [N_DEV-1:0] dir;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_id;
  logic             gnt_valid;
  logic             drop_d;
  state_t           state;
`ifdef STATE_FILTER_EN
  logic [N_DEV-1:0] map_q;
  logic [N_DEV-1:0] map_d;
`endif

  rr_arbiter #(.N_DEV(N_DEV), .PTR_W(PTR_W)) u_arb (
    .req   (dev_pend),
    .ptr   (ptr),
    .gnt   (gnt),
    .gnt_id(gnt_id),
    .valid (gnt_valid)
  );

  assign change = (state == ISSUE);

  // flatten slot structs into occupancy and direction vectors
  always_comb begin
    dev_pend = '0;
    dir      = '0;
    for (int i = 0; i < N_DEV; i++) begin
      dev_pend[i] = slot_q[i].pend;
      dir[i]      = slot_q[i].dir;
    end
  end

  // slot update: the granted slot frees first, so a same-edge request refills it
  always_comb begin
    slot_d = slot_q;
    drop_d = 1'b0;
`ifdef STATE_FILTER_EN
    map_d = map_q;
    if (gnt_valid) map_d[gnt_id] = dir[gnt_id];
`endif
    for (int i = 0; i < N_DEV; i++) begin
      if (gnt[i]) slot_d[i].pend = 1'b0;
      if (dev_req[i]) begin
        if (!slot_q[i].pend || gnt[i]) begin
`ifdef STATE_FILTER_EN
          if (dev_on[i] == map_d[i]) drop_d = 1'b1;
          else slot_d[i] = '{pend: 1'b1, dir: dev_on[i]};
`else
          slot_d[i] = '{pend: 1'b1, dir: dev_on[i]};
`endif
        end else if (dev_on[i] == slot_q[i].dir) drop_d = 1'b1;
        else slot_d[i].pend = 1'b0;
      end
    end
  end

  // FSM, pointer, slots and registered monitor outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= '{default: '0};
      ptr      <= '0;
      state    <= IDLE;
      on_off   <= 1'b0;
      grant_id <= '0;
      dropped  <= 1'b0;
`ifdef STATE_FILTER_EN
      map_q    <= '0;
`endif
    end else begin
      slot_q  <= slot_d;
      dropped <= drop_d;
      state   <= gnt_valid ? ISSUE : IDLE;
`ifdef STATE_FILTER_EN
      map_q   <= map_d;
`endif
      if (gnt_valid) begin
        on_off   <= dir[gnt_id];
        grant_id <= gnt_id;
        ptr      <= (int'(gnt_id) == N_DEV - 1) ? '0 : gnt_id + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_iot_event_sched.sv
// tb_iot_event_sched: randomized and directed self-checking bench against a queue-level event model
module tb_iot_event_sched;
`ifdef STATE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dev_req = 4'hF;
  logic [3:0] dev_on = 4'hF;
  logic [3:0] dev_pend;
  logic       dropped, change, on_off;
  logic [1:0] grant_id;
  int checks = 0;
  int errors = 0;

  bit m_pend[4], m_dir[4], m_map[4];
  int m_ptr = 0;
  bit e_change = 0, e_on = 0, e_drop = 0;
  int e_gid = 0;

  iot_event_sched dut (
    .clk(clk), .rst(rst), .dev_req(dev_req), .dev_on(dev_on), .dev_pend(dev_pend),
    .dropped(dropped), .change(change), .on_off(on_off), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pend_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // model: one event per edge, oldest pointer order, free-then-capture per device
  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0; m_dir[i] = 0; m_map[i] = 0;
      end
      m_ptr = 0; e_change = 0; e_on = 0; e_gid = 0; e_drop = 0;
    end else begin
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      e_change = (g >= 0);
      e_drop = 0;
      if (g >= 0) begin
        e_on = m_dir[g]; e_gid = g; m_pend[g] = 0; m_map[g] = m_dir[g]; m_ptr = (g + 1) % 4;
      end
      for (int i = 0; i < 4; i++)
        if (dev_req[i]) begin
          if (m_pend[i]) begin
            if (m_dir[i] == dev_on[i]) e_drop = 1;
            else m_pend[i] = 0;
          end else if (FILT && m_map[i] == dev_on[i]) e_drop = 1;
          else begin
            m_pend[i] = 1; m_dir[i] = dev_on[i];
          end
        end
    end
  end

  // compare every cycle against the model
  always @(negedge clk) begin
    chk("change", change, e_change);
    chk("on_off", on_off, e_on);
    chk("grant_id", grant_id, e_gid);
    chk("dropped", dropped, e_drop);
    chk("dev_pend", dev_pend, pend_vec());
  end

  task automatic cyc(input logic [3:0] r, input logic [3:0] o);
    dev_req = r;
    dev_on = o;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; dev_req = 0; dev_on = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // reset held with all requests active
    repeat (2) begin
      @(negedge clk);
      chk("rst_change", change, 0);
      chk("rst_pend", dev_pend, 0);
      chk("rst_gid", grant_id, 0);
    end
    rst = 1'b0;
    // single event
    cyc(4'b0100, 4'b0100);
    chk("single_pend", dev_pend, 4'b0100);
    chk("single_lat", change, 0);
    cyc(0, 0);
    chk("single_change", change, 1);
    chk("single_on", on_off, 1);
    chk("single_gid", grant_id, 2);
    cyc(0, 0);
    chk("single_idle", change, 0);
    // contention and pointer wrap
    do_reset();
    cyc(4'hF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0);
      chk("burst_change", change, 1);
      chk("burst_gid", grant_id, i);
    end
    cyc(0, 0);
    chk("burst_idle", change, 0);
    cyc(4'hF, FILT ? 4'h0 : 4'hF);
    cyc(0, 0);
    chk("wrap_gid", grant_id, 0);
    chk("wrap_change", change, 1);
    repeat (4) cyc(0, 0);
    // cancelling pair on device 2
    do_reset();
    cyc(4'b0111, 4'b0111);
    cyc(4'b0100, 4'b0000);
    chk("cancel_pend", dev_pend, 4'b0010);
    chk("cancel_drop", dropped, 0);
    chk("cancel_gid", grant_id, 0);
    cyc(0, 0);
    chk("cancel_gid1", grant_id, 1);
    cyc(0, 0);
    chk("cancel_no_dev2", change, 0);
    // duplicate on device 2
    do_reset();
    cyc(4'b0111, 4'b0111);
    cyc(4'b0100, 4'b0100);
    chk("dup_drop", dropped, 1);
    cyc(0, 0);
    chk("dup_drop_pulse", dropped, 0);
    chk("dup_gid1", grant_id, 1);
    cyc(0, 0);
    chk("dup_gid2", grant_id, 2);
    cyc(0, 0);
    chk("dup_single", change, 0);
    // reset in the middle of a burst
    do_reset();
    cyc(4'hF, 4'hF);
    cyc(0, 0);
    chk("mid_first", change, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_change", change, 0);
    chk("mid_pend", dev_pend, 0);
    @(negedge clk);
    rst = 1'b0;
`ifdef STATE_FILTER_EN
    do_reset();
    cyc(4'b0010, 4'b0000);
    chk("filt_off_drop", dropped, 1);
    chk("filt_off_pend", dev_pend, 0);
    cyc(0, 0);
    chk("filt_off_nochg", change, 0);
    cyc(4'b0010, 4'b0010);
    cyc(0, 0);
    chk("filt_on_chg", change, 1);
    chk("filt_on_dir", on_off, 1);
    chk("filt_on_gid", grant_id, 1);
    cyc(4'b0010, 4'b0010);
    chk("filt_again_drop", dropped, 1);
`endif
    // randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc(4'($urandom & $urandom), 4'($urandom));
    end
    repeat (8) cyc(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
